// File: rtl/fp_divider_single_seq.sv
// fp_divider_single_seq
//   Iterative IEEE-754 single-precision divider, Div_Out = A / B.
//   The mantissa quotient comes from a 25-step radix-2 restoring divider
//   (one quotient bit per clock). The result is truncated toward zero.
//   Latency is fixed at 27 cycles from the start edge to done, specials
//   included.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request, sampled only while idle
//   A, B        in   dividend / divisor, IEEE-754 single
//   busy        out  high whenever the FSM is not idle
//   done        out  one-cycle pulse when Div_Out is valid
//   Div_Out     out  quotient, held until the next done
//   div_by_zero out  nonzero / zero flag, valid with done and held with Div_Out
module fp_divider_single_seq #(
    parameter int          EXP_BIAS   = 127,
    parameter int unsigned ITERATIONS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Div_Out,
    output logic        div_by_zero
);

    localparam int unsigned CntW = $clog2(ITERATIONS);

    typedef enum logic [2:0] {StIdle, StPrep, StDiv, StNorm, StDone} state_e;
    typedef enum logic [2:0] {SpNone, SpNan, SpDivZero, SpInf, SpZero} special_e;

    state_e            state_q;
    special_e          special_q;
    special_e          special;
    logic [31:0]       a_q, b_q;
    logic              sign_q;
    logic [23:0]       mb_q;
    logic [24:0]       r_q;
    logic [24:0]       q_q;
    logic signed [9:0] exp_tmp_q;
    logic [CntW-1:0]   cnt_q;

    // Field split and classification of the latched operands
    logic [7:0]        a_exp, b_exp;
    logic [22:0]       a_man, b_man;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [9:0] exp_diff;

    // Restoring divider step and normalisation
    logic              r_ge;
    logic [24:0]       r_rem;
    logic [24:0]       r_shift;
    logic [22:0]       norm_man;
    logic signed [9:0] norm_exp;
    logic [31:0]       result;

    always_comb begin
        a_exp    = a_q[30:23];
        b_exp    = b_q[30:23];
        a_man    = a_q[22:0];
        b_man    = b_q[22:0];
        // Exponent 0 covers both zero and denormals; both are treated as zero
        a_zero   = (a_exp == 8'h00);
        b_zero   = (b_exp == 8'h00);
        a_inf    = (a_exp == 8'hFF) && (a_man == 23'd0);
        b_inf    = (b_exp == 8'hFF) && (b_man == 23'd0);
        a_nan    = (a_exp == 8'hFF) && (a_man != 23'd0);
        b_nan    = (b_exp == 8'hFF) && (b_man != 23'd0);
        exp_diff = signed'({2'b00, a_exp}) - signed'({2'b00, b_exp});

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special = SpNan;
        end else if (b_zero) begin
            special = SpDivZero;
        end else if (a_inf) begin
            special = SpInf;
        end else if (b_inf || a_zero) begin
            special = SpZero;
        end else begin
            special = SpNone;
        end

        // R < Mb after each subtract, so the shift never loses a set bit
        r_ge    = (r_q >= {1'b0, mb_q});
        r_rem   = r_ge ? (r_q - {1'b0, mb_q}) : r_q;
        r_shift = r_rem << 1;

        if (q_q[24]) begin
            norm_man = q_q[23:1];
            norm_exp = exp_tmp_q + signed'(10'(EXP_BIAS));
        end else begin
            norm_man = q_q[22:0];
            norm_exp = exp_tmp_q + signed'(10'(EXP_BIAS)) - 10'sd1;
        end

        unique case (special_q)
            SpNan:     result = 32'h7FC0_0000;
            SpDivZero: result = {sign_q, 31'h7F80_0000};
            SpInf:     result = {sign_q, 8'hFF, 23'd0};
            SpZero:    result = {sign_q, 31'd0};
            default: begin
                if (norm_exp <= 10'sd0) begin
                    result = {sign_q, 31'd0};
                end else if (norm_exp >= 10'sd255) begin
                    result = {sign_q, 8'hFF, 23'd0};
                end else begin
                    result = {sign_q, norm_exp[7:0], norm_man};
                end
            end
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            special_q   <= SpNone;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sign_q      <= 1'b0;
            mb_q        <= 24'd0;
            r_q         <= 25'd0;
            q_q         <= 25'd0;
            exp_tmp_q   <= 10'sd0;
            cnt_q       <= '0;
            done        <= 1'b0;
            Div_Out     <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        state_q <= StPrep;
                    end
                end
                StPrep: begin
                    sign_q    <= a_q[31] ^ b_q[31];
                    mb_q      <= {1'b1, b_man};
                    r_q       <= {2'b01, a_man};
                    exp_tmp_q <= exp_diff;
                    special_q <= special;
                    q_q       <= 25'd0;
                    cnt_q     <= '0;
                    state_q   <= StDiv;
                end
                StDiv: begin
                    // Shifting in MSB-first lands the first bit at q[24]
                    q_q   <= {q_q[23:0], r_ge};
                    r_q   <= r_shift;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(ITERATIONS - 1)) begin
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    Div_Out     <= result;
                    div_by_zero <= (special_q == SpDivZero);
                    done        <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
